inst_loader: RTL and testbench

INST_LOADER -- requirements
Module: inst_loader

---
 rtl/loader_pkg.sv | 16 +
 rtl/byte_pack.sv | 33 +++
 rtl/inst_loader.sv | 139 +++++++++++++
 tb/tb_inst_loader.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// Shared definitions for the instruction loader: FSM state encoding and the NOP
// instruction returned to the core whenever no valid program word is available.
package loader_pkg;

  typedef enum logic [2:0] {
    WAIT_LEN0 = 3'd0,
    WAIT_LEN1 = 3'd1,
    LOAD      = 3'd2,
    CHECK     = 3'd3,
    DONE      = 3'd4,
    ERROR     = 3'd5
  } loader_state_e;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

endpackage

// File: rtl/byte_pack.sv
// Assembles a stream of bytes into little-endian 32-bit words; word_valid_o
// pulses combinationally with the 4th byte so the word can be written on that edge.
module byte_pack (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  byte_i,
  input  logic        byte_valid_i,
  output logic [31:0] word_o,
  output logic        word_valid_o
);

  logic [1:0]  lane_q;
  logic [23:0] data_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      lane_q <= 2'd0;
      data_q <= 24'd0;
    end else if (byte_valid_i) begin
      lane_q <= lane_q + 2'd1;
      case (lane_q)
        2'd0:    data_q[7:0]   <= byte_i;
        2'd1:    data_q[15:8]  <= byte_i;
        2'd2:    data_q[23:16] <= byte_i;
        default: ;
      endcase
    end
  end

  assign word_o       = {byte_i, data_q};
  assign word_valid_o = byte_valid_i && (lane_q == 2'd3);

endmodule

// File: rtl/inst_loader.sv
// Boot loader: receives a length-prefixed program over a byte stream, fills the
// instruction memory, then releases the core. Optional LOADER_CHECKSUM_EN adds a trailing XOR byte check.
module inst_loader
  import loader_pkg::*;
#(
  parameter int DEPTH  = 4096,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic        rx_ready_o,
  input  logic [31:0] inst_addr_i,
  output logic [31:0] inst_o,
  output logic        core_rst_o,
  output logic [15:0] words_o,
  output logic        err_o
);

  loader_state_e state_q;
  logic [7:0]    lenLo_q;
  logic [15:0]   len_q;
  logic [16:0]   wordCnt_q;
  logic          err_q;

  logic [31:0]   mem [DEPTH];

  logic          accept;
  logic          packValid;
  logic          wordValid;
  logic [31:0]   packWord;
  logic [15:0]   len_d;
  logic [16:0]   wordCnt_d;
  logic [ADDR_W-1:0] rdIdx;
  logic          inRange;

`ifdef LOADER_CHECKSUM_EN
  localparam loader_state_e AFTER_LOAD = CHECK;
  logic [7:0] csum_q;
  logic [7:0] csum_d;
  assign csum_d = csum_q ^ rx_data_i;
`else
  localparam loader_state_e AFTER_LOAD = DONE;
`endif

  // Ready is forced low while reset is held so no byte can slip in on a reset edge.
  assign rx_ready_o = rst && (state_q inside {WAIT_LEN0, WAIT_LEN1, LOAD, CHECK});
  assign accept     = rx_valid_i && rx_ready_o;
  assign packValid  = accept && (state_q == LOAD);
  assign len_d      = {rx_data_i, lenLo_q};
  assign wordCnt_d  = wordCnt_q + 17'd1;

  byte_pack u_byte_pack (
    .clk          (clk),
    .rst          (rst),
    .byte_i       (rx_data_i),
    .byte_valid_i (packValid),
    .word_o       (packWord),
    .word_valid_o (wordValid)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= WAIT_LEN0;
      lenLo_q   <= 8'd0;
      len_q     <= 16'd0;
      wordCnt_q <= 17'd0;
      err_q     <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum_q    <= 8'd0;
`endif
    end else begin
      case (state_q)
        WAIT_LEN0: begin
          if (accept) begin
            lenLo_q <= rx_data_i;
            state_q <= WAIT_LEN1;
          end
        end
        WAIT_LEN1: begin
          if (accept) begin
            len_q <= len_d;
            if (len_d == 16'd0) begin
              state_q <= AFTER_LOAD;
            end else if (32'(len_d) > DEPTH) begin
              state_q <= ERROR;
              err_q   <= 1'b1;
            end else begin
              state_q <= LOAD;
            end
          end
        end
        LOAD: begin
          if (wordValid) begin
            wordCnt_q <= wordCnt_d;
            if (wordCnt_d == {1'b0, len_q}) begin
              state_q <= AFTER_LOAD;
            end
          end
        end
`ifdef LOADER_CHECKSUM_EN
        CHECK: begin
          if (accept) begin
            if (rx_data_i == csum_q) begin
              state_q <= DONE;
            end else begin
              state_q <= ERROR;
              err_q   <= 1'b1;
            end
          end
        end
`endif
        default: ;
      endcase
`ifdef LOADER_CHECKSUM_EN
      if (accept && (state_q != CHECK)) begin
        csum_q <= csum_d;
      end
`endif
    end
  end

  // Program memory is deliberately not reset so a soft reset keeps the old image.
  always_ff @(posedge clk) begin
    if (wordValid) begin
      mem[wordCnt_q[ADDR_W-1:0]] <= packWord;
    end
  end

  assign rdIdx   = inst_addr_i[ADDR_W+1:2];
  assign inRange = (inst_addr_i[31:ADDR_W+2] == '0);
  assign inst_o  = ((state_q == DONE) && inRange) ? mem[rdIdx] : NOP_INST;

  assign core_rst_o = (state_q == DONE);
  assign err_o      = err_q;
  assign words_o    = wordCnt_q[16] ? 16'hFFFF : wordCnt_q[15:0];

endmodule

// File: tb/tb_inst_loader.sv
// Self-checking bench for inst_loader: directed scenarios plus randomized loads
// checked against a queue-based reference of the expected memory image.
module tb_inst_loader;

  localparam int          DEPTH = 4096;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data_i;
  logic        rx_valid_i;
  logic        rx_ready_o;
  logic [31:0] inst_addr_i;
  logic [31:0] inst_o;
  logic        core_rst_o;
  logic [15:0] words_o;
  logic        err_o;

  int nCompared   = 0;
  int nMismatched = 0;

  logic [31:0] prog[$];
  logic [7:0]  byteQ[$];

  always #5 clk = ~clk;

  inst_loader #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_data_i   (rx_data_i),
    .rx_valid_i  (rx_valid_i),
    .rx_ready_o  (rx_ready_o),
    .inst_addr_i (inst_addr_i),
    .inst_o      (inst_o),
    .core_rst_o  (core_rst_o),
    .words_o     (words_o),
    .err_o       (err_o)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCompared++;
    assert (obs === exp) else begin
      nMismatched++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reset for one edge and check the reset-cycle outputs, then release.
  task automatic applyReset();
    rst         = 1'b0;
    rx_valid_i  = 1'b0;
    inst_addr_i = 32'd0;
    @(posedge clk); #1;
    checkOutput("rstReady",   32'(rx_ready_o), 32'd0);
    checkOutput("rstCoreRst", 32'(core_rst_o), 32'd0);
    checkOutput("rstWords",   32'(words_o),    32'd0);
    checkOutput("rstErr",     32'(err_o),      32'd0);
    checkOutput("rstInst",    inst_o,          NOP);
    rst = 1'b1;
    #1;
    checkOutput("readyAfterRst", 32'(rx_ready_o), 32'd1);
  endtask

  // Offer one byte until it is accepted (bounded), optionally idle one cycle after.
  task automatic applyStimulus(input logic [7:0] b, input bit gap);
    int n;
    n          = 0;
    rx_data_i  = b;
    rx_valid_i = 1'b1;
    while (!rx_ready_o && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("readyWait", 32'(rx_ready_o), 32'd1);
    @(posedge clk); #1;
    rx_valid_i = 1'b0;
    if (gap) begin
      @(posedge clk); #1;
    end
  endtask

  // Reference byte stream: LE count, LE words, optional XOR of everything before it.
  task automatic buildBytes();
    logic [15:0] n;
    logic [7:0]  cs;
    byteQ.delete();
    n = 16'(prog.size());
    byteQ.push_back(n[7:0]);
    byteQ.push_back(n[15:8]);
    foreach (prog[k]) begin
      for (int j = 0; j < 4; j++) byteQ.push_back(8'(prog[k] >> (8 * j)));
    end
`ifdef LOADER_CHECKSUM_EN
    cs = 8'd0;
    foreach (byteQ[i]) cs = cs ^ byteQ[i];
    byteQ.push_back(cs);
`else
    cs = 8'd0;
`endif
  endtask

  task automatic runLoad(input bit gap, input string name);
    int last;
    buildBytes();
    last = byteQ.size() - 1;
    for (int i = 0; i < last; i++) applyStimulus(byteQ[i], gap);
    checkOutput({name, ":coreRstBefore"}, 32'(core_rst_o), 32'd0);
    applyStimulus(byteQ[last], 1'b0);
    checkOutput({name, ":coreRstAfter"}, 32'(core_rst_o), 32'd1);
    checkOutput({name, ":words"},        32'(words_o),    32'(prog.size()));
    checkOutput({name, ":err"},          32'(err_o),      32'd0);
    checkOutput({name, ":readyDone"},    32'(rx_ready_o), 32'd0);
    foreach (prog[k]) begin
      inst_addr_i = 32'(k) * 32'd4 + 32'($urandom_range(0, 3));
      #1;
      checkOutput($sformatf("%s:mem[%0d]", name, k), inst_o, prog[k]);
    end
  endtask

  task automatic randomProg(input int n);
    prog.delete();
    for (int i = 0; i < n; i++) prog.push_back($urandom());
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] saved[$];
    rst         = 1'b0;
    rx_valid_i  = 1'b0;
    rx_data_i   = 8'd0;
    inst_addr_i = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    applyReset();

    // Two-word directed program.
    prog = '{32'h0010_0513, 32'h0020_0593};
    runLoad(1'b0, "basic");
    inst_addr_i = 32'h0000_0007; #1;
    checkOutput("lowBitsIgnored", inst_o, 32'h0020_0593);
    inst_addr_i = 32'h0001_0000; #1;
    checkOutput("outOfRange", inst_o, NOP);

    // Empty program: DONE straight after the header; memory survives reset.
    applyReset();
    prog.delete();
    runLoad(1'b0, "empty");
    inst_addr_i = 32'h0001_0000; #1;
    checkOutput("emptyOutOfRange", inst_o, NOP);
    inst_addr_i = 32'h0000_0000; #1;
    checkOutput("memKept", inst_o, 32'h0010_0513);

    // Oversized count goes to ERROR and stays there.
    applyReset();
    applyStimulus(8'h01, 1'b0);
    applyStimulus(8'h10, 1'b0);
    checkOutput("ovfErr",     32'(err_o),      32'd1);
    checkOutput("ovfReady",   32'(rx_ready_o), 32'd0);
    checkOutput("ovfCoreRst", 32'(core_rst_o), 32'd0);
    checkOutput("ovfInst",    inst_o,          NOP);
    rx_data_i  = 8'h55;
    rx_valid_i = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    rx_valid_i = 1'b0;
    checkOutput("ovfErrSticky", 32'(err_o),   32'd1);
    checkOutput("ovfWords",     32'(words_o), 32'd0);

    // Same 3-word image with toggling valid and back-to-back.
    applyReset();
    randomProg(3);
    saved = prog;
    runLoad(1'b1, "toggle");
    applyReset();
    prog = saved;
    runLoad(1'b0, "b2b");

    // Reset after 6 of 8 payload bytes, then a fresh load.
    applyReset();
    randomProg(2);
    buildBytes();
    for (int i = 0; i < 8; i++) applyStimulus(byteQ[i], 1'b0);
    checkOutput("abortWordsBefore", 32'(words_o),    32'd1);
    checkOutput("abortCoreRst",     32'(core_rst_o), 32'd0);
    applyReset();
    randomProg(2);
    runLoad(1'b0, "reload");

    // Randomized lengths and pacing.
    for (int r = 0; r < 4; r++) begin
      applyReset();
      randomProg($urandom_range(1, 24));
      runLoad(1'($urandom_range(0, 1)), $sformatf("rand%0d", r));
    end

`ifdef LOADER_CHECKSUM_EN
    // Corrupted checksum byte must end in ERROR.
    applyReset();
    randomProg(2);
    buildBytes();
    byteQ[byteQ.size() - 1] = ~byteQ[byteQ.size() - 1];
    foreach (byteQ[i]) applyStimulus(byteQ[i], 1'b0);
    checkOutput("badCsumErr",     32'(err_o),      32'd1);
    checkOutput("badCsumCoreRst", 32'(core_rst_o), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
